// File: rtl/window_3x3_gen_pkg.sv
// Shared definitions for the 3x3 window generator and the downstream median datapath.
package window_3x3_gen_pkg;

  // Sequencing state of the window generator.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Window slot indices: slot = 3*row + col, row 0 is the top row, col 0 the left column.
  localparam int WIN_TL     = 0;
  localparam int WIN_TC     = 1;
  localparam int WIN_TR     = 2;
  localparam int WIN_ML     = 3;
  localparam int WIN_CENTER = 4;
  localparam int WIN_MR     = 5;
  localparam int WIN_BL     = 6;
  localparam int WIN_BC     = 7;
  localparam int WIN_BR     = 8;
  localparam int WIN_SIZE   = 9;

endpackage

// File: rtl/window_3x3_gen_line_buffer.sv
// One image row of pixel storage: combinational read, registered write to the same address.
// Reading and writing the same slot in one cycle returns the old content.
module line_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int DEPTH      = 640,
  parameter int ADDR_W     = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [ADDR_W-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  assign rdata = mem_r[addr];

  // Store the incoming pixel; contents are deliberately not reset.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[addr] <= wdata;
    end
  end

endmodule

// File: rtl/window_3x3_gen.sv
// Converts a raster pixel stream into 3x3 neighbourhood windows for the median filter.
// Two line buffers keep the previous two rows; a 3x3 register array holds the live window.
// Only interior windows are flagged valid; border positions are suppressed by row/col gating.
module window_3x3_gen
  import window_3x3_gen_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int IMG_WIDTH  = 640,
  parameter int IMG_HEIGHT = 480
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             in_valid,
  input  logic                             in_sof,
  input  logic [DATA_WIDTH-1:0]            DATA_IN,
  output logic [WIN_SIZE*DATA_WIDTH-1:0]   win,
  output logic                             win_valid,
  output logic                             frame_done,
  output logic                             sof_err
);

  localparam int COL_W = $clog2(IMG_WIDTH);
  localparam int ROW_W = $clog2(IMG_HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);
  localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
  localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
  localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
  localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
  localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
  localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);

  state_t                           state_r;
  logic [COL_W-1:0]                 col_r, cur_col_s, col_next_s;
  logic [ROW_W-1:0]                 row_r, cur_row_s, row_next_s;
  logic                             accept_s, last_pix_s, win_pos_s, sof_mid_s;
  logic [DATA_WIDTH-1:0]            lb0_rd_s, lb1_rd_s;
  logic [WIN_SIZE*DATA_WIDTH-1:0]   win_r, win_next_s;
  logic                             win_valid_r, frame_done_r, sof_err_r;

  // LB0 holds the row just above the current one, LB1 the row above that.
  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb0 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (cur_col_s),
    .wdata (DATA_IN),
    .rdata (lb0_rd_s)
  );

  line_buffer #(.DATA_WIDTH(DATA_WIDTH), .DEPTH(IMG_WIDTH), .ADDR_W(COL_W)) u_lb1 (
    .clk   (clk),
    .we    (accept_s),
    .addr  (cur_col_s),
    .wdata (lb0_rd_s),
    .rdata (lb1_rd_s)
  );

  // Pixel acceptance, effective position (sof forces origin) and next counter values.
  always_comb begin
    accept_s  = in_valid & (in_sof | (state_r == ST_RUN));
    sof_mid_s = in_valid & in_sof & (state_r == ST_RUN) &
                ((row_r != ROW_ZERO) | (col_r != COL_ZERO));
    if (in_sof) begin
      cur_col_s = COL_ZERO;
      cur_row_s = ROW_ZERO;
    end else begin
      cur_col_s = col_r;
      cur_row_s = row_r;
    end
    last_pix_s = (cur_row_s == ROW_LAST) && (cur_col_s == COL_LAST);
    win_pos_s  = (cur_row_s >= ROW_TWO) && (cur_col_s >= COL_TWO);
    if (cur_col_s == COL_LAST) begin
      col_next_s = COL_ZERO;
      if (cur_row_s == ROW_LAST) begin
        row_next_s = ROW_ZERO;
      end else begin
        row_next_s = cur_row_s + ROW_ONE;
      end
    end else begin
      col_next_s = cur_col_s + COL_ONE;
      row_next_s = cur_row_s;
    end
  end

  // Next window: shift every row one column left and load {top, mid, new pixel} on the right.
  always_comb begin
    win_next_s = win_r;
    for (int i = 0; i < 3; i++) begin
      win_next_s[(3*i)*DATA_WIDTH +: DATA_WIDTH]   = win_r[(3*i+1)*DATA_WIDTH +: DATA_WIDTH];
      win_next_s[(3*i+1)*DATA_WIDTH +: DATA_WIDTH] = win_r[(3*i+2)*DATA_WIDTH +: DATA_WIDTH];
    end
    win_next_s[WIN_TR*DATA_WIDTH +: DATA_WIDTH] = lb1_rd_s;
    win_next_s[WIN_MR*DATA_WIDTH +: DATA_WIDTH] = lb0_rd_s;
    win_next_s[WIN_BR*DATA_WIDTH +: DATA_WIDTH] = DATA_IN;
  end

  // FSM, position counters, window registers and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r      <= ST_IDLE;
      col_r        <= COL_ZERO;
      row_r        <= ROW_ZERO;
      win_r        <= '0;
      win_valid_r  <= 1'b0;
      frame_done_r <= 1'b0;
      sof_err_r    <= 1'b0;
    end else begin
      win_valid_r  <= accept_s & win_pos_s;
      frame_done_r <= accept_s & last_pix_s;
      sof_err_r    <= sof_mid_s;
      if (accept_s) begin
        col_r <= col_next_s;
        row_r <= row_next_s;
        win_r <= win_next_s;
        case (state_r)
          ST_IDLE, ST_RUN, ST_DONE: state_r <= last_pix_s ? ST_DONE : ST_RUN;
          default:                  state_r <= ST_IDLE;
        endcase
      end
    end
  end

  assign win        = win_r;
  assign win_valid  = win_valid_r;
  assign frame_done = frame_done_r;
  assign sof_err    = sof_err_r;

endmodule

// File: tb/tb_window_3x3_gen.sv
// Directed self-checking bench for window_3x3_gen on a 4x4 image.
module tb_window_3x3_gen;

  localparam int DW = 8;
  localparam int W  = 4;
  localparam int H  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_sof;
  logic [DW-1:0] data_in;
  logic [9*DW-1:0] win;
  logic          win_valid;
  logic          frame_done;
  logic          sof_err;

  int n_cmp = 0;
  int n_err = 0;

  window_3x3_gen #(.DATA_WIDTH(DW), .IMG_WIDTH(W), .IMG_HEIGHT(H)) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_sof     (in_sof),
    .DATA_IN    (data_in),
    .win        (win),
    .win_valid  (win_valid),
    .frame_done (frame_done),
    .sof_err    (sof_err)
  );

  always #5 clk = ~clk;

  // Expected window whose bottom-right pixel is (r,c) of a frame with pixel = base + 4*r + c.
  function automatic logic [9*DW-1:0] exp_win(input int base, input int r, input int c);
    logic [9*DW-1:0] w;
    w = '0;
    for (int i = 0; i < 3; i++)
      for (int j = 0; j < 3; j++)
        w[(3*i+j)*DW +: DW] = DW'(base + W*(r-2+i) + (c-2+j));
    return w;
  endfunction

  // Drive one cycle of inputs; outputs are sampled 1 time unit after the edge.
  task automatic send(input logic v, input logic s, input logic [DW-1:0] d);
    in_valid = v;
    in_sof   = s;
    data_in  = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_sof   = 1'b0;
    data_in  = 8'd0;
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One complete frame with sof on the first pixel, optional idle cycle after each pixel.
  task automatic run_frame(input int base, input bit gaps, input bit first_err, output int nwin);
    logic [9*DW-1:0] held;
    bit exp_v, exp_last, exp_err;
    nwin = 0;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        send(1'b1, (r == 0 && c == 0), DW'(base + W*r + c));
        exp_v    = (r >= 2 && c >= 2);
        exp_last = (r == H-1 && c == W-1);
        exp_err  = (r == 0 && c == 0) ? first_err : 1'b0;
        n_cmp++;
        if (win_valid !== exp_v) begin
          n_err++;
          $display("FAIL win_valid b=%0d r=%0d c=%0d: got %b expected %b", base, r, c, win_valid, exp_v);
        end
        if (exp_v) begin
          nwin++;
          n_cmp++;
          if (win !== exp_win(base, r, c)) begin
            n_err++;
            $display("FAIL win b=%0d r=%0d c=%0d: got %h expected %h", base, r, c, win, exp_win(base, r, c));
          end
        end
        n_cmp++;
        if (frame_done !== exp_last) begin
          n_err++;
          $display("FAIL frame_done b=%0d r=%0d c=%0d: got %b expected %b", base, r, c, frame_done, exp_last);
        end
        n_cmp++;
        if (sof_err !== exp_err) begin
          n_err++;
          $display("FAIL sof_err b=%0d r=%0d c=%0d: got %b expected %b", base, r, c, sof_err, exp_err);
        end
        if (gaps) begin
          held = win;
          send(1'b0, 1'b0, 8'hA5);
          n_cmp++;
          if (win_valid !== 1'b0 || frame_done !== 1'b0) begin
            n_err++;
            $display("FAIL gap_pulse r=%0d c=%0d: got %b%b expected 00", r, c, win_valid, frame_done);
          end
          n_cmp++;
          if (win !== held) begin
            n_err++;
            $display("FAIL gap_hold r=%0d c=%0d: got %h expected %h", r, c, win, held);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    in_valid = 1'b0;
    in_sof   = 1'b0;
    data_in  = 8'd0;
    reset    = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_cmp++;
    if (win !== 72'd0) begin
      n_err++;
      $display("FAIL reset_win: got %h expected 0", win);
    end
    n_cmp++;
    if ({win_valid, frame_done, sof_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_flags: got %b expected 000", {win_valid, frame_done, sof_err});
    end
  endtask

  task automatic test_continuous();
    int n;
    run_frame(0, 1'b0, 1'b0, n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL continuous_count: got %0d expected 4", n);
    end
    n_cmp++;
    if (win[4*DW +: DW] !== 8'd10) begin
      n_err++;
      $display("FAIL last_centre: got %0d expected 10", win[4*DW +: DW]);
    end
    send(1'b0, 1'b0, 8'd0);
    n_cmp++;
    if ({win_valid, frame_done} !== 2'b00) begin
      n_err++;
      $display("FAIL after_frame: got %b expected 00", {win_valid, frame_done});
    end
  endtask

  task automatic test_gaps();
    int n;
    run_frame(0, 1'b1, 1'b0, n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL gaps_count: got %0d expected 4", n);
    end
  endtask

  task automatic test_no_sof();
    int n;
    apply_reset();
    for (int k = 0; k < W*H; k++) begin
      send(1'b1, 1'b0, DW'(k));
      n_cmp++;
      if ({win_valid, frame_done} !== 2'b00) begin
        n_err++;
        $display("FAIL no_sof k=%0d: got %b expected 00", k, {win_valid, frame_done});
      end
    end
    run_frame(0, 1'b0, 1'b0, n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL no_sof_count: got %0d expected 4", n);
    end
  endtask

  task automatic test_mid_sof();
    int n;
    // Old frame rows 0-1 and pixel (2,0), then sof arrives where (2,1) was due.
    for (int k = 0; k < 2*W + 1; k++) begin
      send(1'b1, (k == 0), DW'(100 + k));
      n_cmp++;
      if ({win_valid, sof_err} !== 2'b00) begin
        n_err++;
        $display("FAIL mid_sof_pre k=%0d: got %b expected 00", k, {win_valid, sof_err});
      end
    end
    run_frame(0, 1'b0, 1'b1, n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL mid_sof_count: got %0d expected 4", n);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    bit exp_v;
    for (int k = 0; k <= 3*W + 1; k++) begin
      send(1'b1, (k == 0), DW'(W*(k/W) + (k%W)));
      exp_v = ((k / W) >= 2) && ((k % W) >= 2);
      n_cmp++;
      if (win_valid !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid_pre k=%0d: got %b expected %b", k, win_valid, exp_v);
      end
    end
    apply_reset();
    n_cmp++;
    if (win !== 72'd0) begin
      n_err++;
      $display("FAIL reset_mid_win: got %h expected 0", win);
    end
    n_cmp++;
    if ({win_valid, frame_done, sof_err} !== 3'b000) begin
      n_err++;
      $display("FAIL reset_mid_flags: got %b expected 000", {win_valid, frame_done, sof_err});
    end
    run_frame(0, 1'b0, 1'b0, n);
    n_cmp++;
    if (n !== 4) begin
      n_err++;
      $display("FAIL reset_mid_count: got %0d expected 4", n);
    end
  endtask

  task automatic test_back_to_back();
    int n0, n1;
    run_frame(0, 1'b0, 1'b0, n0);
    run_frame(16, 1'b0, 1'b0, n1);
    n_cmp++;
    if (n0 + n1 !== 8) begin
      n_err++;
      $display("FAIL b2b_count: got %0d expected 8", n0 + n1);
    end
  endtask

  initial begin
    test_reset();
    test_continuous();
    test_gaps();
    test_no_sof();
    test_mid_sof();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
